// File: rtl/cam_frame_writer.sv
// cam_frame_writer
//
// Captures the RGB565 byte stream of an OV7670-style camera port. It keeps
// every second pixel of every second line and writes the result into a
// row-major frame buffer as 16-bit words at address y*DST_W + x. Camera
// signals are already synchronous to clk. They are qualified by pclk_en.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   pclk_en    byte strobe; vsync, href and data are sampled only when high
//   vsync      frame sync, high between frames
//   href       line valid
//   data       camera byte, high byte of each pixel first
//   we         one-cycle write strobe to the frame buffer
//   wAddr      17-bit word address of the write
//   wData      RGB565 pixel {first_byte, second_byte}
//   frame_done one-cycle pulse when a frame with at least one line ends
//   busy       high while capturing (ACTIVE state)

module cam_frame_writer #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480,
  parameter int DST_W = 320,
  parameter int DST_H = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pclk_en,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        we,
  output logic [16:0] wAddr,
  output logic [15:0] wData,
  output logic        frame_done,
  output logic        busy
);

  // Counter widths leave headroom above the source size. Overlong lines and
  // frames then saturate instead of wrapping back into the valid range.
  localparam int XW = $clog2(SRC_W + 1) + 1;
  localparam int YW = $clog2(SRC_H + 1) + 1;

  localparam logic [XW-1:0] SRC_W_L = XW'(SRC_W);
  localparam logic [YW-1:0] SRC_H_L = YW'(SRC_H);
  localparam logic [XW-1:0] X_MAX   = {XW{1'b1}};
  localparam logic [YW-1:0] Y_MAX   = {YW{1'b1}};
  localparam logic [16:0]   DST_W_A = 17'(DST_W);
  localparam logic [16:0]   DST_H_A = 17'(DST_H);

  typedef enum logic [1:0] {
    WAIT_VS,
    VS_HIGH,
    ACTIVE
  } state_t;

  state_t state;
  state_t next_state;

  logic          byte_ph;
  logic [7:0]    hi_byte;
  logic          href_prev;
  logic [XW-1:0] x_src;
  logic [YW-1:0] y_src;
  logic [YW-1:0] line_cnt;

  logic          start_frame;
  logic          end_frame;
  logic          capture;
  logic          byte_hi;
  logic          byte_lo;
  logic          line_end;
  logic          pix_keep;
  logic          fd_set;
  logic [16:0]   x_half;
  logic [16:0]   y_half;
  logic [16:0]   addr_calc;

  // State register. busy is registered here so that it tracks the state
  // exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_VS;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ACTIVE);
    end
  end

  // Next-state logic. Nothing moves on cycles without a byte strobe. After
  // reset the first vsync high seen is treated as the start of a sync
  // pulse. A full high-to-low sequence is then required before capture, so
  // a partial frame is never written.
  always_comb begin
    next_state = state;
    if (pclk_en) begin
      case (state)
        WAIT_VS: if (vsync)  next_state = VS_HIGH;
        VS_HIGH: if (!vsync) next_state = ACTIVE;
        ACTIVE:  if (vsync)  next_state = VS_HIGH;
        default: next_state = WAIT_VS;
      endcase
    end
  end

  // Output/event decode for the current strobe. vsync has priority over
  // href in ACTIVE. A byte arriving with vsync high belongs to an aborted
  // line and is ignored.
  always_comb begin
    start_frame = pclk_en && (state == VS_HIGH) && !vsync;
    end_frame   = pclk_en && (state == ACTIVE) && vsync;
    capture     = pclk_en && (state == ACTIVE) && !vsync;
    byte_hi     = capture && href && !byte_ph;
    byte_lo     = capture && href && byte_ph;
    line_end    = capture && !href && href_prev;
    fd_set      = end_frame && (line_cnt != '0);

    x_half      = 17'(x_src >> 1);
    y_half      = 17'(y_src >> 1);
    addr_calc   = y_half * DST_W_A + x_half;

    // Keep even pixels of even lines that lie inside the source frame. The
    // destination bound only matters if the source is larger than 2x the
    // destination. It keeps the address inside the buffer in that case.
    pix_keep    = byte_lo && !x_src[0] && !y_src[0] &&
                  (x_src < SRC_W_L) && (y_src < SRC_H_L) &&
                  (x_half < DST_W_A) && (y_half < DST_H_A);
  end

  // Capture datapath and registered write port. we and frame_done default
  // low every cycle. wAddr and wData hold their last value between writes.
  // On a falling href, a dangling high byte is dropped by resetting the
  // phase. The line counts only if it delivered at least one whole pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      byte_ph    <= 1'b0;
      hi_byte    <= '0;
      href_prev  <= 1'b0;
      x_src      <= '0;
      y_src      <= '0;
      line_cnt   <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;

      if (start_frame) begin
        byte_ph   <= 1'b0;
        href_prev <= 1'b0;
        x_src     <= '0;
        y_src     <= '0;
        line_cnt  <= '0;
      end

      if (capture) begin
        href_prev <= href;
      end

      if (byte_hi) begin
        hi_byte <= data;
        byte_ph <= 1'b1;
      end

      if (byte_lo) begin
        byte_ph <= 1'b0;
        if (x_src != X_MAX) begin
          x_src <= x_src + 1'b1;
        end
        if (pix_keep) begin
          we    <= 1'b1;
          wAddr <= addr_calc;
          wData <= {hi_byte, data};
        end
      end

      if (line_end) begin
        byte_ph <= 1'b0;
        x_src   <= '0;
        if (x_src != '0) begin
          if (y_src != Y_MAX) begin
            y_src <= y_src + 1'b1;
          end
          if (line_cnt != Y_MAX) begin
            line_cnt <= line_cnt + 1'b1;
          end
        end
      end

      if (fd_set) begin
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer
//
// Directed bench for cam_frame_writer at its default 640x480 -> 320x240
// geometry. Inputs change 1 time unit after the rising edge. Outputs are
// observed at the falling edge. A monitor collects every write into a
// queue and counts frame_done pulses. It also flags any write strobe
// that is wider than one cycle or that does not follow a byte strobe.
// To keep runtime small, most lines are short. Only the lines that
// exercise the far edge of the frame carry a full 640 pixels.

module tb_cam_frame_writer;

  logic        clk;
  logic        reset;
  logic        pclk_en;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        we;
  logic [16:0] wAddr;
  logic [15:0] wData;
  logic        frame_done;
  logic        busy;

  typedef struct {
    logic [16:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  fd_cnt;
  int  bad_strobe;
  int  checks;
  int  errors;
  int  gap;
  logic we_prev;
  logic pen_prev;

  cam_frame_writer dut (
    .clk        (clk),
    .reset      (reset),
    .pclk_en    (pclk_en),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor. pen_prev holds the strobe value that the DUT sampled on
  // the edge which produced the current outputs.
  always @(negedge clk) begin
    if (we) wr_q.push_back('{a: wAddr, d: wData});
    if (frame_done) fd_cnt++;
    if (we && we_prev) bad_strobe++;
    if (we && !pen_prev) bad_strobe++;
    we_prev  = we;
    pen_prev = pclk_en;
  end

  // One byte strobe, followed by gap idle cycles with pclk_en low.
  task automatic applyStimulus(input logic [7:0] b, input logic h, input logic v);
    @(posedge clk);
    #1;
    pclk_en = 1'b1;
    data    = b;
    href    = h;
    vsync   = v;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      pclk_en = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Stop strobing and let the registered outputs drain into the monitor.
  task automatic settle(input int n);
    @(posedge clk);
    #1;
    pclk_en = 1'b0;
    href    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line of npix pixels {hi, x[7:0]}, then one strobe with href low.
  task automatic send_line(input logic [7:0] hi, input int npix);
    for (int x = 0; x < npix; x++) begin
      applyStimulus(hi, 1'b1, 1'b0);
      applyStimulus(8'(x), 1'b1, 1'b0);
    end
    applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame_start();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [16:0] q_addr(input int i);
    return (i < wr_q.size()) ? wr_q[i].a : 17'h1FFFF;
  endfunction

  function automatic logic [15:0] q_data(input int i);
    return (i < wr_q.size()) ? wr_q[i].d : 16'hFFFF;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    fd_cnt     = 0;
    bad_strobe = 0;
    gap        = 0;
    we_prev    = 1'b0;
    pen_prev   = 1'b0;
    reset      = 1'b1;
    pclk_en    = 1'b0;
    vsync      = 1'b0;
    href       = 1'b0;
    data       = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_we",   32'(we),         32'h0);
    checkOutput("rst_addr", 32'(wAddr),      32'h0);
    checkOutput("rst_data", 32'(wData),      32'h0);
    checkOutput("rst_fd",   32'(frame_done), 32'h0);
    checkOutput("rst_busy", 32'(busy),       32'h0);
    reset = 1'b0;

    // Pixels before any vsync are ignored
    send_line(8'h55, 4);
    settle(3);
    checkOutput("presync_writes", 32'(wr_q.size()), 32'd0);
    checkOutput("presync_busy",   32'(busy),        32'h0);

    // Byte order: A5 3C then 11 22; only x=0 is written
    frame_start();
    applyStimulus(8'hA5, 1'b1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    settle(3);
    checkOutput("order_busy",   32'(busy),        32'h1);
    checkOutput("order_writes", 32'(wr_q.size()), 32'd1);
    checkOutput("order_addr",   32'(q_addr(0)),   32'h0);
    checkOutput("order_data",   32'(q_data(0)),   32'hA53C);
    wr_q.delete();

    // Overlong line with dangling byte, then odd and even lines
    frame_start();
    for (int x = 0; x < 642; x++) begin
      applyStimulus(8'h10, 1'b1, 1'b0);
      applyStimulus(8'(x), 1'b1, 1'b0);
    end
    applyStimulus(8'h77, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    send_line(8'h11, 4);
    send_line(8'h22, 4);
    settle(3);
    checkOutput("long_fd",      32'(fd_cnt),      32'd1);
    checkOutput("long_writes",  32'(wr_q.size()), 32'd322);
    checkOutput("long_last_a",  32'(q_addr(319)), 32'd319);
    checkOutput("long_last_d",  32'(q_data(319)), 32'h107E);
    checkOutput("long_next_a",  32'(q_addr(320)), 32'd320);
    checkOutput("long_next_d",  32'(q_data(320)), 32'h2200);
    checkOutput("long_next2_a", 32'(q_addr(321)), 32'd321);
    wr_q.delete();

    // Frame reaching the far corner: short lines up to y=477, then a full
    // line at y=478, a short y=479, and y=480, which lies beyond the frame
    frame_start();
    for (int y = 0; y < 478; y++) send_line(8'(y), 2);
    send_line(8'hDE, 640);
    send_line(8'hDF, 2);
    send_line(8'hE0, 2);
    applyStimulus(8'h00, 1'b0, 1'b1);
    settle(3);
    checkOutput("full_writes", 32'(wr_q.size()), 32'd559);
    checkOutput("full_first_a", 32'(q_addr(0)),  32'd0);
    checkOutput("full_first_d", 32'(q_data(0)),  32'h0000);
    checkOutput("full_y476_a",  32'(q_addr(238)), 32'd76160);
    checkOutput("full_y476_d",  32'(q_data(238)), 32'hDC00);
    checkOutput("full_last_a",  32'(q_addr(558)), 32'd76799);
    checkOutput("full_last_d",  32'(q_data(558)), 32'hDE7E);
    checkOutput("full_fd",      32'(fd_cnt),      32'd3);
    wr_q.delete();

    // Mid-frame abort after 10.5 lines, then a fresh frame
    frame_start();
    for (int y = 0; y < 10; y++) send_line(8'(y), 4);
    applyStimulus(8'h0A, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h0A, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'hAB, 1'b1, 1'b0);
    applyStimulus(8'h99, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    settle(3);
    checkOutput("abort_fd",     32'(fd_cnt),      32'd4);
    checkOutput("abort_writes", 32'(wr_q.size()), 32'd12);
    checkOutput("abort_l10_a",  32'(q_addr(10)),  32'd1600);
    checkOutput("abort_l10_d",  32'(q_data(10)),  32'h0A00);
    checkOutput("abort_new_a",  32'(q_addr(11)),  32'd0);
    checkOutput("abort_new_d",  32'(q_data(11)),  32'h1234);
    wr_q.delete();

    // Gated strobe, one cycle in three
    gap = 2;
    frame_start();
    send_line(8'h50, 4);
    send_line(8'h51, 2);
    send_line(8'h52, 4);
    settle(4);
    gap = 0;
    checkOutput("gated_writes", 32'(wr_q.size()), 32'd4);
    checkOutput("gated_a0", 32'(q_addr(0)), 32'd0);
    checkOutput("gated_d0", 32'(q_data(0)), 32'h5000);
    checkOutput("gated_a1", 32'(q_addr(1)), 32'd1);
    checkOutput("gated_d1", 32'(q_data(1)), 32'h5002);
    checkOutput("gated_a2", 32'(q_addr(2)), 32'd320);
    checkOutput("gated_d3", 32'(q_data(3)), 32'h5202);
    checkOutput("strobe_shape", 32'(bad_strobe), 32'd0);
    wr_q.delete();

    // Async reset during line 5
    frame_start();
    for (int y = 0; y < 5; y++) send_line(8'(y), 2);
    applyStimulus(8'h05, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h05, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    pclk_en = 1'b0;
    #2;
    checkOutput("pre_rst_busy", 32'(busy),  32'h1);
    checkOutput("pre_rst_addr", 32'(wAddr), 32'd640);
    checkOutput("pre_rst_data", 32'(wData), 32'h0400);
    reset = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy),       32'h0);
    checkOutput("arst_addr", 32'(wAddr),      32'h0);
    checkOutput("arst_data", 32'(wData),      32'h0);
    checkOutput("arst_we",   32'(we),         32'h0);
    checkOutput("arst_fd",   32'(frame_done), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_q.delete();
    send_line(8'h06, 4);
    send_line(8'h07, 4);
    settle(3);
    checkOutput("arst_nosync_writes", 32'(wr_q.size()), 32'd0);
    frame_start();
    send_line(8'h3C, 2);
    settle(3);
    checkOutput("arst_resume_writes", 32'(wr_q.size()), 32'd1);
    checkOutput("arst_resume_a", 32'(q_addr(0)), 32'd0);
    checkOutput("arst_resume_d", 32'(q_data(0)), 32'h3C00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
